// File: rtl/memc_dump_reader.sv
// Walks every entry of a memc-style cache array over its combinational read port
// and streams each entry out as one valid/ready beat tagged with index and file_id.
module memc_dump_reader #(
    parameter int unsigned Size  = 16,
    parameter int unsigned Depth = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            abort,
    input  logic [4:0]      file_id,
    output logic [7:0]      mem_addr,
    input  logic [Size-1:0] mem_data,
    input  logic            mem_write,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [Size-1:0] out_data,
    output logic [7:0]      out_index,
    output logic [4:0]      out_file_id,
    output logic            out_last,
    output logic            busy,
    output logic            done
);

    localparam int unsigned IDX_W    = 8;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(Depth - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        SEND = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] idx;

    // idx is only advanced below LAST_IDX, so it never wraps and upper bits stay 0.
    assign mem_addr = idx;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            idx         <= '0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_index   <= '0;
            out_file_id <= '0;
            out_last    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        out_file_id <= file_id;
                        idx         <= '0;
                        busy        <= 1'b1;
                        state       <= READ;
                    end
                end
                READ: begin
                    if (abort) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end else if (!mem_write) begin
                        // Array reads 0 during a write, so capture only on a quiet cycle.
                        out_data  <= mem_data;
                        out_index <= idx;
                        out_last  <= (idx == LAST_IDX);
                        out_valid <= 1'b1;
                        state     <= SEND;
                    end
                end
                SEND: begin
                    if (abort) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        if (out_last) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            idx   <= idx + IDX_W'(1);
                            state <= READ;
                        end
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_memc_dump_reader.sv
// Scoreboard bench for memc_dump_reader: stimulus queues expected beats, a
// negedge monitor compares every presented beat against the queue head.
module tb_memc_dump_reader;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [4:0]  file_id = 5'd0;
    logic [7:0]  mem_addr;
    logic [15:0] mem_data;
    logic        mem_write = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_data;
    logic [7:0]  out_index;
    logic [4:0]  out_file_id;
    logic        out_last;
    logic        busy;
    logic        done;

    memc_dump_reader #(.Size(16), .Depth(32)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .file_id(file_id),
        .mem_addr(mem_addr), .mem_data(mem_data), .mem_write(mem_write),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_index(out_index), .out_file_id(out_file_id), .out_last(out_last),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    logic [15:0] mem [256];
    assign mem_data = mem_write ? 16'h0000 : mem[mem_addr];

    typedef struct packed {
        logic [15:0] data;
        logic [7:0]  index;
        logic [4:0]  fid;
        logic        last;
    } beat_t;

    beat_t exp_q[$];
    int vectors = 0;
    int errors  = 0;
    int done_cnt = 0;
    int cyc = 0;
    int t0 = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        vectors++;
        errors++;
        $display("FAIL %s: got timeout expected event", name);
    endtask

    // Monitor: compare presented beat to queue head; pop when the handshake will complete.
    always @(negedge clk) begin
        if (rst && out_valid) begin
            if (exp_q.size() == 0) begin
                vectors++;
                errors++;
                $display("FAIL unexpected_beat: got index %0d expected no beat", out_index);
            end else begin
                check("beat_data",  32'(out_data),    32'(exp_q[0].data));
                check("beat_index", 32'(out_index),   32'(exp_q[0].index));
                check("beat_fid",   32'(out_file_id), 32'(exp_q[0].fid));
                check("beat_last",  32'(out_last),    32'(exp_q[0].last));
                if (out_ready && !abort) void'(exp_q.pop_front());
            end
        end
        if (rst && done) done_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_beats(input int n, input logic [4:0] f);
        for (int i = 0; i < n; i++) begin
            beat_t b;
            b.data  = 16'(16'hA500 + i);
            b.index = 8'(i);
            b.fid   = f;
            b.last  = (i == 31);
            exp_q.push_back(b);
        end
    endtask

    task automatic start_dump(input logic [4:0] f);
        file_id = f;
        start = 1'b1;
        tick();
        start = 1'b0;
        file_id = 5'd0;
        t0 = cyc;
    endtask

    task automatic wait_beat(input logic [7:0] ix);
        for (int i = 0; i < 500; i++) begin
            if (out_valid && out_index == ix) return;
            tick();
        end
        fail("wait_beat");
    endtask

    task automatic wait_done(output int cycles);
        cycles = -1;
        for (int i = 0; i < 3000; i++) begin
            if (done) begin
                cycles = cyc - t0;
                return;
            end
            tick();
        end
        fail("wait_done");
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_valid"}, 32'(out_valid),   32'd0);
        check({tag, "_busy"},  32'(busy),        32'd0);
        check({tag, "_done"},  32'(done),        32'd0);
        check({tag, "_data"},  32'(out_data),    32'd0);
        check({tag, "_index"}, 32'(out_index),   32'd0);
        check({tag, "_fid"},   32'(out_file_id), 32'd0);
        check({tag, "_last"},  32'(out_last),    32'd0);
        check({tag, "_addr"},  32'(mem_addr),    32'd0);
    endtask

    initial begin
        int cycles;
        int dc;
        for (int i = 0; i < 256; i++) mem[i] = 16'(16'hA500 + i);

        // Reset state
        tick();
        tick();
        check_idle_outputs("reset");
        rst = 1'b1;
        tick();

        // Test 1: full dump, ready always high
        out_ready = 1'b1;
        dc = done_cnt;
        push_beats(32, 5'd12);
        start_dump(5'd12);
        check("t1_busy", 32'(busy), 32'd1);
        wait_done(cycles);
        check("t1_done_cycle", 32'(cycles), 32'd64);
        check("t1_busy_in_done", 32'(busy), 32'd1);
        tick();
        check("t1_done_pulse", 32'(done), 32'd0);
        check("t1_busy_after", 32'(busy), 32'd0);
        check("t1_queue_empty", 32'(exp_q.size()), 32'd0);
        check("t1_done_count", 32'(done_cnt - dc), 32'd1);

        // Test 2: random backpressure
        dc = done_cnt;
        push_beats(32, 5'd3);
        start_dump(5'd3);
        begin : t2_loop
            for (int i = 0; i < 3000; i++) begin
                if (done) disable t2_loop;
                out_ready = 1'($urandom_range(0, 1));
                tick();
            end
            fail("t2_timeout");
        end
        out_ready = 1'b1;
        tick();
        check("t2_queue_empty", 32'(exp_q.size()), 32'd0);
        check("t2_done_count", 32'(done_cnt - dc), 32'd1);

        // Test 3: write stall while reading entry 5
        push_beats(32, 5'd7);
        start_dump(5'd7);
        begin : t3_wait
            for (int i = 0; i < 100; i++) begin
                if (busy && !out_valid && mem_addr == 8'd5) disable t3_wait;
                tick();
            end
            fail("t3_wait_read5");
        end
        mem_write = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t3_stall_valid", 32'(out_valid), 32'd0);
        end
        mem_write = 1'b0;
        tick();
        check("t3_valid", 32'(out_valid), 32'd1);
        check("t3_data", 32'(out_data), 32'hA505);
        wait_done(cycles);
        check("t3_done_cycle", 32'(cycles), 32'd67);
        tick();

        // Test 4: start during a dump is ignored
        dc = done_cnt;
        push_beats(32, 5'd21);
        start_dump(5'd21);
        wait_beat(8'd10);
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(cycles);
        check("t4_done_cycle", 32'(cycles), 32'd64);
        for (int i = 0; i < 4; i++) tick();
        check("t4_idle_valid", 32'(out_valid), 32'd0);
        check("t4_idle_busy", 32'(busy), 32'd0);
        check("t4_done_count", 32'(done_cnt - dc), 32'd1);

        // Test 5: reset in SEND at index 7, then fresh dump
        push_beats(8, 5'd12);
        start_dump(5'd12);
        wait_beat(8'd7);
        rst = 1'b0;
        tick();
        check_idle_outputs("t5_rst");
        check("t5_left_in_queue", 32'(exp_q.size()), 32'd1);
        exp_q.delete();
        rst = 1'b1;
        tick();
        push_beats(32, 5'd9);
        start_dump(5'd9);
        wait_done(cycles);
        check("t5_done_cycle", 32'(cycles), 32'd64);
        tick();
        check("t5_queue_empty", 32'(exp_q.size()), 32'd0);

        // Test 6: abort in SEND at index 20 with ready high
        dc = done_cnt;
        push_beats(21, 5'd4);
        start_dump(5'd4);
        wait_beat(8'd20);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("t6_valid", 32'(out_valid), 32'd0);
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_done", 32'(done), 32'd0);
        check("t6_left_in_queue", 32'(exp_q.size()), 32'd1);
        exp_q.delete();
        for (int i = 0; i < 6; i++) tick();
        check("t6_still_idle", 32'(busy), 32'd0);
        check("t6_no_done", 32'(done_cnt - dc), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
